// File: rtl/debug_slave_sysclk_bridge_if.sv
// ============================================================================
// Module   : debug_slave_sysclk_bridge_if
// Brief    : JTAG-side capture and sysclk action handshake bundle for the bridge
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface debug_slave_sysclk_bridge_if #(
  parameter int IR_W   = 2,
  parameter int DATA_W = 38
);
  localparam int NUM_CH = 2**IR_W;

  logic [IR_W-1:0]   ir_in;
  logic [DATA_W-1:0] sr;
  logic              vs_udr;
  logic              vs_uir;
  logic              act_ready;
  logic              clr_overrun;
  logic [DATA_W-1:0] jdo;
  logic [NUM_CH-1:0] take_action;
  logic [NUM_CH-1:0] take_no_action;
  logic              act_valid;
  logic              ir_changed;
  logic              overrun;

  modport master (
    output ir_in, sr, vs_udr, vs_uir, act_ready, clr_overrun,
    input  jdo, take_action, take_no_action, act_valid, ir_changed, overrun
  );

  modport slave (
    input  ir_in, sr, vs_udr, vs_uir, act_ready, clr_overrun,
    output jdo, take_action, take_no_action, act_valid, ir_changed, overrun
  );
endinterface

`default_nettype wire

// File: rtl/debug_slave_sysclk_bridge.sv
// ============================================================================
// Module   : debug_slave_sysclk_bridge
// Brief    : Moves JTAG update-DR/IR strobes into sysclk and issues one-hot actions
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_slave_sysclk_bridge #(
  parameter int IR_W        = 2,
  parameter int DATA_W      = 38,
  parameter int SYNC_STAGES = 2
) (
  input logic                        clk,
  input logic                        reset,
  debug_slave_sysclk_bridge_if.slave bus
);
  localparam int NUM_CH = 2**IR_W;
  localparam int CNT_W  = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] c_suppress_init = CNT_W'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_udr_sync;
  logic [SYNC_STAGES-1:0] r_uir_sync;
  logic                   r_udr_dly;
  logic                   r_uir_dly;
  logic [CNT_W-1:0]       r_suppress;
  logic                   w_events_ok;
  logic                   w_udr_evt;
  logic                   w_uir_evt;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_capture;
  logic                   w_drop;
  logic [DATA_W-1:0]      r_jdo;
  logic [IR_W-1:0]        r_ch;
  logic                   r_overrun;
  logic                   r_ir_changed;
  logic [NUM_CH-1:0]      w_onehot;

  // Suppress counter hides the false edge seen while the delay flops catch up
  // with a strobe that was already high when reset was released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_udr_sync <= '0;
      r_uir_sync <= '0;
      r_udr_dly  <= 1'b0;
      r_uir_dly  <= 1'b0;
      r_suppress <= c_suppress_init;
    end else begin
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], bus.vs_udr};
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], bus.vs_uir};
      r_udr_dly  <= r_udr_sync[SYNC_STAGES-1];
      r_uir_dly  <= r_uir_sync[SYNC_STAGES-1];
      if (r_suppress != '0) begin
        r_suppress <= r_suppress - CNT_W'(1);
      end
    end
  end

  assign w_events_ok = (r_suppress == '0);
  assign w_udr_evt   = w_events_ok & r_udr_sync[SYNC_STAGES-1] & ~r_udr_dly;
  assign w_uir_evt   = w_events_ok & r_uir_sync[SYNC_STAGES-1] & ~r_uir_dly;

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_udr_evt) begin
          w_capture    = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_drop       = w_udr_evt;
        w_state_next = bus.act_ready ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (bus.act_ready) begin
          if (w_udr_evt) begin
            w_capture    = 1'b1;
            w_state_next = S_ISSUE;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_drop = w_udr_evt;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_jdo        <= '0;
      r_ch         <= '0;
      r_overrun    <= 1'b0;
      r_ir_changed <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_ir_changed <= w_uir_evt;
      if (w_capture) begin
        r_jdo <= bus.sr;
        r_ch  <= bus.ir_in;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (bus.clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  always_comb begin
    w_onehot       = '0;
    w_onehot[r_ch] = 1'b1;
  end

  // Outputs decode from registered state only, so an async reset clears them at once.
  assign bus.jdo            = r_jdo;
  assign bus.take_action    = (r_state == S_ISSUE &&  r_jdo[DATA_W-1]) ? w_onehot : '0;
  assign bus.take_no_action = (r_state == S_ISSUE && !r_jdo[DATA_W-1]) ? w_onehot : '0;
  assign bus.act_valid      = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign bus.ir_changed     = r_ir_changed;
  assign bus.overrun        = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_debug_slave_sysclk_bridge.sv
// ============================================================================
// Module   : tb_debug_slave_sysclk_bridge
// Brief    : Directed bench for the default build and a wide three-stage build
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debug_slave_sysclk_bridge;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  debug_slave_sysclk_bridge_if #(.IR_W(2), .DATA_W(38)) bus0 ();
  debug_slave_sysclk_bridge_if #(.IR_W(3), .DATA_W(42)) bus1 ();

  debug_slave_sysclk_bridge #(.IR_W(2), .DATA_W(38), .SYNC_STAGES(2)) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  debug_slave_sysclk_bridge #(.IR_W(3), .DATA_W(42), .SYNC_STAGES(3)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus0.ir_in = '0; bus0.sr = '0; bus0.vs_udr = 1'b0; bus0.vs_uir = 1'b0;
    bus0.act_ready = 1'b0; bus0.clr_overrun = 1'b0;
    bus1.ir_in = '0; bus1.sr = '0; bus1.vs_udr = 1'b0; bus1.vs_uir = 1'b0;
    bus1.act_ready = 1'b0; bus1.clr_overrun = 1'b0;

    step(2);
    check("rst_jdo",       64'(bus0.jdo), 64'h0);
    check("rst_take",      64'(bus0.take_action), 64'h0);
    check("rst_notake",    64'(bus0.take_no_action), 64'h0);
    check("rst_valid",     64'(bus0.act_valid), 64'h0);
    check("rst_irchg",     64'(bus0.ir_changed), 64'h0);
    check("rst_overrun",   64'(bus0.overrun), 64'h0);
    check("rst_u1_jdo",    64'(bus1.jdo), 64'h0);
    reset = 1'b0;
    step(5);

    // Action bit set, ir 2, accepted immediately; pulse lands after edge 3.
    bus0.sr = 38'h20_0000_0ABC; bus0.ir_in = 2'd2; bus0.act_ready = 1'b1; bus0.vs_udr = 1'b1;
    step(1);
    check("t1_e1_valid",   64'(bus0.act_valid), 64'h0);
    step(1);
    check("t1_e2_take",    64'(bus0.take_action), 64'h0);
    step(1);
    check("t1_e3_take",    64'(bus0.take_action), 64'h4);
    check("t1_e3_notake",  64'(bus0.take_no_action), 64'h0);
    check("t1_e3_valid",   64'(bus0.act_valid), 64'h1);
    check("t1_e3_jdo",     64'(bus0.jdo), 64'h20_0000_0ABC);
    step(1);
    check("t1_e4_take",    64'(bus0.take_action), 64'h0);
    check("t1_e4_valid",   64'(bus0.act_valid), 64'h0);
    bus0.vs_udr = 1'b0;
    step(4);

    // Action bit clear, ir 1, consumer stalls: act_valid held six cycles.
    bus0.sr = 38'h00_1234_5678; bus0.ir_in = 2'd1; bus0.act_ready = 1'b0; bus0.vs_udr = 1'b1;
    step(2);
    bus0.vs_udr = 1'b0;
    step(1);
    check("t2_e3_notake",  64'(bus0.take_no_action), 64'h2);
    check("t2_e3_take",    64'(bus0.take_action), 64'h0);
    check("t2_e3_valid",   64'(bus0.act_valid), 64'h1);
    step(1);
    check("t2_e4_notake",  64'(bus0.take_no_action), 64'h0);
    check("t2_e4_valid",   64'(bus0.act_valid), 64'h1);
    step(4);
    check("t2_e8_valid",   64'(bus0.act_valid), 64'h1);
    check("t2_e8_notake",  64'(bus0.take_no_action), 64'h0);
    bus0.act_ready = 1'b1;
    step(1);
    check("t2_e9_valid",   64'(bus0.act_valid), 64'h0);
    bus0.act_ready = 1'b0;
    step(3);

    // Overrun: second update arrives while waiting.
    bus0.sr = 38'h3F_0000_0001; bus0.ir_in = 2'd3; bus0.vs_udr = 1'b1;
    step(1);
    bus0.vs_udr = 1'b0;
    step(2);
    check("t3_e3_take",    64'(bus0.take_action), 64'h8);
    step(2);
    bus0.sr = 38'h01_1111_1111; bus0.ir_in = 2'd0; bus0.vs_udr = 1'b1;
    step(1);
    bus0.vs_udr = 1'b0;
    step(2);
    check("t3_ovr_set",    64'(bus0.overrun), 64'h1);
    check("t3_jdo_keep",   64'(bus0.jdo), 64'h3F_0000_0001);
    check("t3_valid",      64'(bus0.act_valid), 64'h1);
    check("t3_no_repulse", 64'(bus0.take_action | bus0.take_no_action), 64'h0);
    bus0.clr_overrun = 1'b1;
    step(1);
    check("t3_ovr_clr",    64'(bus0.overrun), 64'h0);
    bus0.clr_overrun = 1'b0;
    bus0.vs_udr = 1'b1;
    step(1);
    bus0.vs_udr = 1'b0;
    step(1);
    bus0.clr_overrun = 1'b1;
    step(1);
    check("t3_set_wins",   64'(bus0.overrun), 64'h1);
    check("t3_jdo_keep2",  64'(bus0.jdo), 64'h3F_0000_0001);
    step(1);
    bus0.clr_overrun = 1'b0;
    check("t3_ovr_clr2",   64'(bus0.overrun), 64'h0);

    // Update coinciding with acceptance in WAIT is taken, not dropped.
    bus0.sr = 38'h2A_AAAA_5555; bus0.ir_in = 2'd1; bus0.vs_udr = 1'b1;
    step(1);
    bus0.vs_udr = 1'b0;
    step(1);
    bus0.act_ready = 1'b1;
    step(1);
    check("t4_jdo",        64'(bus0.jdo), 64'h2A_AAAA_5555);
    check("t4_take",       64'(bus0.take_action), 64'h2);
    check("t4_valid",      64'(bus0.act_valid), 64'h1);
    check("t4_overrun",    64'(bus0.overrun), 64'h0);
    step(1);
    check("t4_idle",       64'(bus0.act_valid), 64'h0);
    bus0.act_ready = 1'b0;

    // Strobe held high across reset release yields no event.
    reset = 1'b1; bus0.vs_udr = 1'b1;
    step(3);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("t5_hold_valid", 64'(bus0.act_valid), 64'h0);
      check("t5_hold_pulse", 64'(bus0.take_action | bus0.take_no_action), 64'h0);
    end
    bus0.vs_udr = 1'b0;
    step(4);

    // Asynchronous reset while waiting clears everything mid-cycle.
    bus0.sr = 38'h3C_DEAD_BEEF; bus0.ir_in = 2'd2; bus0.vs_udr = 1'b1;
    step(1);
    bus0.vs_udr = 1'b0;
    step(3);
    check("t5_wait_valid", 64'(bus0.act_valid), 64'h1);
    #2 reset = 1'b1;
    #1;
    check("t5_ar_valid",   64'(bus0.act_valid), 64'h0);
    check("t5_ar_jdo",     64'(bus0.jdo), 64'h0);
    check("t5_ar_pulse",   64'(bus0.take_action | bus0.take_no_action), 64'h0);
    check("t5_ar_flags",   64'({bus0.overrun, bus0.ir_changed}), 64'h0);
    step(1);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("t5_rel_valid", 64'(bus0.act_valid), 64'h0);
    end

    // Wide build: three stages give four cycles of latency, channel 7.
    bus1.sr = 42'h200_0000_0001; bus1.ir_in = 3'd7; bus1.act_ready = 1'b1; bus1.vs_udr = 1'b1;
    step(3);
    check("t6_g3_take",    64'(bus1.take_action), 64'h0);
    step(1);
    bus1.vs_udr = 1'b0;
    check("t6_g4_take",    64'(bus1.take_action), 64'h80);
    check("t6_g4_notake",  64'(bus1.take_no_action), 64'h0);
    check("t6_g4_jdo",     64'(bus1.jdo), 64'h200_0000_0001);
    step(1);
    check("t6_g5_take",    64'(bus1.take_action), 64'h0);
    check("t6_g5_valid",   64'(bus1.act_valid), 64'h0);
    step(3);

    // Update-IR strobe on both builds.
    bus0.vs_uir = 1'b1; bus1.vs_uir = 1'b1;
    step(1);
    bus0.vs_uir = 1'b0; bus1.vs_uir = 1'b0;
    step(1);
    check("t7_u0_h2",      64'(bus0.ir_changed), 64'h0);
    step(1);
    check("t7_u0_h3",      64'(bus0.ir_changed), 64'h1);
    check("t7_u1_h3",      64'(bus1.ir_changed), 64'h0);
    step(1);
    check("t7_u0_h4",      64'(bus0.ir_changed), 64'h0);
    check("t7_u1_h4",      64'(bus1.ir_changed), 64'h1);
    step(1);
    check("t7_u1_h5",      64'(bus1.ir_changed), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
